// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the I/D cache to memory arbiter.
// Line/address widths, FSM state codes and grant-side codes.
package mem_arbiter_pkg;

    localparam int ADDR_W = 28;
    localparam int LINE_W = 128;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one slow line-wide memory port
// between the instruction cache and the data cache.
import mem_arbiter_pkg::*;

module mem_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_grant_q;
    logic       grant_v;
    logic       grant_side;
    logic       i_req;
    logic       d_req;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign grant_v = (state_q == IDLE) && (i_req || d_req);

    // On contention, alternate away from whichever side won last.
    always_comb begin
        grant_side = GNT_I;
        unique case (1'b1)
            (i_req && d_req):
                grant_side = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
            (d_req && !i_req):
                grant_side = GNT_D;
            default:
                grant_side = GNT_I;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_v)
                    state_d = (grant_side == GNT_D) ? D_BUSY : I_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (mem_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_ready = (state_q == I_BUSY) && mem_ready;
        d_ready = (state_q == D_BUSY) && mem_ready;
        i_rdata = mem_rdata;
        d_rdata = mem_rdata;
    end

    // Write wins over read if the D cache ever raises both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_I;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else if (grant_v) begin
            last_grant_q <= grant_side;
            if (grant_side == GNT_D) begin
                mem_read  <= d_read & ~d_write;
                mem_write <= d_write;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else begin
                mem_read  <= 1'b1;
                mem_write <= 1'b0;
                mem_addr  <= i_addr;
            end
        end else if (state_q != IDLE && mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// The bench plays the memory and both caches.
import mem_arbiter_pkg::*;

module tb_mem_arbiter;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    localparam logic [LINE_W-1:0] WB_LINE =
        128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
    localparam logic [LINE_W-1:0] RD_LINE0 =
        128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [LINE_W-1:0] RD_LINE1 =
        128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            failures++;
            $display("FAIL reset_req got=%b exp=00", {mem_read, mem_write});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_addr_data got=%h/%h exp=0/0", mem_addr, mem_wdata);
        end
        checks++;
        if ({i_ready, d_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00", {i_ready, d_ready});
        end
        tick();
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_i_fill;
        apply_reset();
        i_read = 1'b1;
        i_addr = 28'h0000123;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL ifill_t0 got=%b exp=0", mem_read);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000123) begin
                failures++;
                $display("FAIL ifill_req cyc=%0d got=%b%b/%h exp=10/0000123",
                         k, mem_read, mem_write, mem_addr);
            end
        end
        tick();
        mem_ready = 1'b1;
        mem_rdata = RD_LINE0;
        #1;
        checks++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== RD_LINE0) begin
            failures++;
            $display("FAIL ifill_done got=%b%b/%h exp=10/%h",
                     i_ready, d_ready, i_rdata, RD_LINE0);
        end
        tick();
        mem_ready = 1'b0;
        i_read = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL ifill_after got=%b%b exp=00", mem_read, i_ready);
        end
    endtask

    task automatic test_d_wb_refill;
        apply_reset();
        d_write = 1'b1;
        d_addr  = 28'h00000A0;
        d_wdata = WB_LINE;
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h00000A0
            || mem_wdata !== WB_LINE) begin
            failures++;
            $display("FAIL dwb_req got=%b%b/%h/%h exp=01/00000a0/%h",
                     mem_read, mem_write, mem_addr, mem_wdata, WB_LINE);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL dwb_done got=%b%b exp=01", i_ready, d_ready);
        end
        tick();
        mem_ready = 1'b0;
        d_write = 1'b0;
        d_read  = 1'b1;
        d_addr  = 28'h00000B0;
        d_wdata = '0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL dwb_gap got=%b%b exp=00", mem_read, mem_write);
        end
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h00000B0
            || mem_wdata !== '0) begin
            failures++;
            $display("FAIL drd_req got=%b%b/%h/%h exp=10/00000b0/0",
                     mem_read, mem_write, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1;
        mem_rdata = RD_LINE1;
        #1;
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== RD_LINE1) begin
            failures++;
            $display("FAIL drd_done got=%b%b/%h exp=01/%h",
                     i_ready, d_ready, d_rdata, RD_LINE1);
        end
        tick();
        mem_ready = 1'b0;
        d_read = 1'b0;
    endtask

    task automatic test_contention;
        apply_reset();
        i_read = 1'b1; i_addr = 28'h0000111;
        d_read = 1'b1; d_addr = 28'h0000222;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000222) begin
            failures++;
            $display("FAIL cont1_grant got=%b/%h exp=1/0000222", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_ready, d_ready} !== 2'b01) begin
            failures++;
            $display("FAIL cont1_ready got=%b exp=01", {i_ready, d_ready});
        end
        // D keeps asking (next line) so the following IDLE cycle contends again.
        tick();
        mem_ready = 1'b0;
        d_addr = 28'h0000223;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000111) begin
            failures++;
            $display("FAIL cont2_grant got=%b/%h exp=1/0000111", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_ready, d_ready} !== 2'b10) begin
            failures++;
            $display("FAIL cont2_ready got=%b exp=10", {i_ready, d_ready});
        end
        tick();
        mem_ready = 1'b0;
        i_read = 1'b0;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000223) begin
            failures++;
            $display("FAIL cont3_grant got=%b/%h exp=1/0000223", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        d_read = 1'b0;
    endtask

    task automatic test_busy_hold;
        apply_reset();
        d_read = 1'b1;
        d_addr = 28'h00000C0;
        tick();
        i_read = 1'b1;
        i_addr = 28'h0000333;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h00000C0) begin
                failures++;
                $display("FAIL hold_req cyc=%0d got=%b%b/%h exp=10/00000c0",
                         k, mem_read, mem_write, mem_addr);
            end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_ready, d_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_dready got=%b exp=01", {i_ready, d_ready});
        end
        tick();
        mem_ready = 1'b0;
        d_read = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL hold_gap got=%b exp=0", mem_read);
        end
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000333) begin
            failures++;
            $display("FAIL hold_igrant got=%b/%h exp=1/0000333", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_ready, d_ready} !== 2'b10) begin
            failures++;
            $display("FAIL hold_iready got=%b exp=10", {i_ready, d_ready});
        end
        tick();
        mem_ready = 1'b0;
        i_read = 1'b0;
    endtask

    task automatic test_spurious;
        apply_reset();
        tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_ready, d_ready} !== 2'b00) begin
            failures++;
            $display("FAIL spur_ready got=%b exp=00", {i_ready, d_ready});
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            failures++;
            $display("FAIL spur_req got=%b exp=00", {mem_read, mem_write});
        end
        i_read = 1'b1;
        i_addr = 28'h0000444;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000444) begin
            failures++;
            $display("FAIL spur_idle got=%b/%h exp=1/0000444", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        tick();
        mem_ready = 1'b0;
        i_read = 1'b0;
    endtask

    task automatic test_async_reset;
        apply_reset();
        d_write = 1'b1;
        d_addr  = 28'h00000DD;
        d_wdata = WB_LINE;
        tick();
        checks++;
        if (mem_write !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre got=%b exp=1", mem_write);
        end
        #2 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00 || mem_addr !== '0) begin
            failures++;
            $display("FAIL arst_drop got=%b/%h exp=00/0", {mem_read, mem_write}, mem_addr);
        end
        checks++;
        if ({i_ready, d_ready} !== 2'b00) begin
            failures++;
            $display("FAIL arst_ready got=%b exp=00", {i_ready, d_ready});
        end
        #2 rst_n = 1'b1;
        mem_ready = 1'b0;
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h00000DD
            || mem_wdata !== WB_LINE) begin
            failures++;
            $display("FAIL arst_regrant got=%b%b/%h/%h exp=01/00000dd/%h",
                     mem_read, mem_write, mem_addr, mem_wdata, WB_LINE);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({i_ready, d_ready} !== 2'b01) begin
            failures++;
            $display("FAIL arst_done got=%b exp=01", {i_ready, d_ready});
        end
        tick();
        mem_ready = 1'b0;
        d_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_d_wb_refill();
        test_contention();
        test_busy_hold();
        test_spurious();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
